// File: rtl/mem_pkg.sv
// Constants and control-state encoding shared by the memory line responder
// and the cache fill controller.
package mem_pkg;

    localparam int unsigned ADDR_W           = 16;
    localparam int unsigned DATA_W           = 16;
    localparam int unsigned LINE_WORDS       = 8;
    localparam int unsigned LINE_OFFSET_BITS = 4;
    // Width of the word-within-line counter.
    localparam int unsigned CNT_W            = $clog2(LINE_WORDS);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StDrain = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_latency_pipe.sv
// Fixed-latency delay line for issued line words. Only the valid bits are
// reset, so an asynchronous reset drops every in-flight word at once.
module mem_latency_pipe
    import mem_pkg::*;
#(
    parameter int unsigned LATENCY = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    input  logic [ADDR_W-1:0] in_addr_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              line_done_o
);

    logic [LATENCY-1:0] vld_q;
    logic [ADDR_W-1:0]  addr_q [LATENCY];
    logic [DATA_W-1:0]  data_q [LATENCY];

    // Valid bits shift one stage per cycle and clear asynchronously.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= in_valid_i;
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    // Payload shifts alongside; it only carries meaning where the valid bit is set.
    always_ff @(posedge clk_i) begin
        addr_q[0] <= in_addr_i;
        data_q[0] <= in_data_i;
        for (int i = 1; i < LATENCY; i++) begin
            addr_q[i] <= addr_q[i-1];
            data_q[i] <= data_q[i-1];
        end
    end

    // Outputs read zero when no word is present; the last word of a line is
    // recognised by its in-line word offset.
    always_comb begin
        out_valid_o = vld_q[LATENCY-1];
        out_addr_o  = out_valid_o ? addr_q[LATENCY-1] : '0;
        out_data_o  = out_valid_o ? data_q[LATENCY-1] : '0;
        line_done_o = out_valid_o && (addr_q[LATENCY-1][LINE_OFFSET_BITS-1:1] == '1);
    end

endmodule

// File: rtl/memory_line_responder.sv
// Main-memory responder: single-word writes complete at the accepting edge;
// line reads stream all eight words of the addressed line, word 0 first,
// through a fixed-latency pipe.
module memory_line_responder
    import mem_pkg::*;
#(
    parameter int unsigned LATENCY   = 4,
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              busy,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic [ADDR_W-1:0] resp_addr,
    output logic              line_done
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);

    mem_state_e                         state_q, state_d;
    logic [CNT_W-1:0]                   cnt_q, cnt_d;
    logic [ADDR_W-1:LINE_OFFSET_BITS]   base_q, base_d;

    logic [DATA_W-1:0] mem_q [MEM_WORDS];

    logic              ready;
    logic              wr_en;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_addr;
    logic [DATA_W-1:0] issue_data;
    logic              pipe_valid;
    logic              pipe_last;
    logic              unused_addr_lsb;

    // Byte lane select is meaningless for 16-bit words.
    assign unused_addr_lsb = req_addr[0];

    // Line reads always start at word 0 of the latched line.
    assign issue_addr = {base_q, cnt_q, 1'b0};
    assign issue_data = mem_q[issue_addr[IDX_W:1]];

    // Next state, issue strobe and handshake. Ready comes back during the
    // final word so a follow-on request can be taken without a bubble.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        base_d      = base_q;
        ready       = 1'b0;
        issue_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                ready = 1'b1;
            end
            StIssue: begin
                issue_valid = 1'b1;
                cnt_d       = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(LINE_WORDS - 1)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (pipe_last) begin
                    ready   = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (ready && req_valid && !req_write) begin
            base_d  = req_addr[ADDR_W-1:LINE_OFFSET_BITS];
            cnt_d   = '0;
            state_d = StIssue;
        end
    end

    assign wr_en     = ready && req_valid && req_write;
    assign req_ready = ready;
    assign busy      = !ready;

    // Control registers; reset abandons any line in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
        end
    end

    // Backing store keeps its contents across reset; index wraps by truncation.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[req_addr[IDX_W:1]] <= req_wdata;
        end
    end

    mem_latency_pipe #(
        .LATENCY (LATENCY)
    ) u_pipe (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (issue_valid),
        .in_addr_i   (issue_addr),
        .in_data_i   (issue_data),
        .out_valid_o (pipe_valid),
        .out_addr_o  (resp_addr),
        .out_data_o  (resp_data),
        .line_done_o (pipe_last)
    );

    assign resp_valid = pipe_valid;
    assign line_done  = pipe_last;

endmodule

// File: doc/memory_line_responder.md
# memory_line_responder

Main-memory responder serving the data cache's line-fill requests. Accepts a read request, returns the full 8-word (16-byte) line containing the address, one word per cycle after a fixed access latency, marking each word with `resp_valid`. Also accepts single-word writes. Sits between the cache fill controller and the word-addressed backing store, which it contains.

## Interface
- `LATENCY`, 4: cycles from word issue to word on `resp_data`; legal range 1..8.
- `MEM_WORDS`, 1024: storage depth in 16-bit words; power of two.
- `clk` in 1: the single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request strobe; sampled only when `req_ready`=1.
- `req_write` in 1: 1 = single-word write, 0 = line read.
- `req_addr` in 16: byte address; bit 0 ignored.
- `req_wdata` in 16: write data.
- `req_ready` out 1: block idle; a request is accepted at a rising edge with `req_valid`=1.
- `busy` out 1: equals `!req_ready`; usable as a stall.
- `resp_valid` out 1: `resp_data` holds a valid line word this cycle.
- `resp_data` out 16: returned word; 0 when `resp_valid`=0.
- `resp_addr` out 16: byte address of the returned word; 0 when `resp_valid`=0.
- `line_done` out 1: high with the 8th word of a line only.

## Operation
- Word index = `req_addr[15:1]` mod `MEM_WORDS`. Line base = `req_addr & 16'hFFF0`.
- States: IDLE, ISSUE, DRAIN.
- IDLE: `req_ready`=1.
  - Write accepted: storage updated at the accepting edge; state stays IDLE; no response.
  - Read accepted: latch the line base, clear the 3-bit issue counter, go to ISSUE.
  - `req_valid`=0: stay in IDLE.
- ISSUE: for 8 cycles, read word `base+2*k` from storage, k = 0..7 in ascending order, always starting at offset 0. Push {valid, addr, data} into the latency pipe. After k=7, go to DRAIN.
- DRAIN: wait until the last word exits the pipe, then return to IDLE.
- `req_valid` while `req_ready`=0 is ignored, with no side effects. Write data is not captured.
- Address wrap: the index wraps modulo `MEM_WORDS`. The line base never crosses a line, and the offset counter wraps 7→0 internally.
- Reset: asynchronous and usable mid-burst.
  - Clears state to IDLE and clears all pipe valids; an in-flight line is abandoned.
  - Storage contents are not reset.
  - Output reset values: `req_ready`=1, `busy`=0, `resp_valid`=0, `resp_data`=0, `resp_addr`=0, `line_done`=0.

## Timing
- Read accepted at edge E0. Word k is issued at edge E0+1+k.
- Word k is presented (`resp_valid`=1) in the cycle following edge E0+k+LATENCY. With LATENCY=4, words appear after edges 4..11.
- Words are contiguous: exactly 8 consecutive `resp_valid` cycles with no gaps.
- `line_done`=1 only in the word-7 cycle.
- `req_ready` is low from the cycle after E0 through the cycle before word 7. It rises in the same cycle as `line_done`, so a back-to-back request is sampled at edge E0+8+LATENCY.
- Read data is taken from storage at issue time. A write accepted at edge t is visible to a read accepted at edge t+1.
- Writes complete at the accepting edge; `req_ready` stays 1 across them (one write per cycle).

## Structure
- Shared package `mem_pkg`:
  - `ADDR_W`=16, `DATA_W`=16, `LINE_WORDS`=8, `LINE_OFFSET_BITS`=4.
  - The state encoding {IDLE, ISSUE, DRAIN}.
  - These constants are shared with the cache fill controller.
- Sub-module `mem_latency_pipe`:
  - A `LATENCY`-stage shift register of {valid, addr[15:0], data[15:0]} with asynchronous reset clearing the valids.
  - `line_done` is derived at its output as valid && addr[3:1]==7.
- Storage array, state register and issue counter are inline in the top.

## Test plan
- Reset then idle: assert `rst` mid-cycle → all outputs at reset values immediately; `req_ready`=1; no `resp_valid` for 20 cycles.
- Write then line read: write 16'hA000+i to byte addresses 16'h0040+2i (i = 0..7), then read at 16'h0046 → after edges 4..11, `resp_data` = A000..A007 and `resp_addr` = 0040..004E; `line_done` with A007.
- Back-to-back reads: a read of line 16'h0040 followed at the first ready edge by a read of line 16'h0080 → 16 words with exactly 4 idle cycles between the lines (LATENCY=4); each `line_done` fires once.
- Ignored request: pulse a write to 16'h0042 with value 16'hDEAD while busy → storage unchanged; a later read of that line returns the original A001.
- Mid-burst reset: assert `rst` after word 3 of a line → `resp_valid` drops asynchronously and no further words appear; storage retained; a re-read returns the full correct line.
- Wrap: with MEM_WORDS=1024, write 16'h1234 to byte address 16'h0800 → a read of 16'h0000 returns 16'h1234 as word 0.
